// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor: the requester drives
// start and the operands, and the subtractor returns status and the result.
interface serial_sub_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_i;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_o;
  logic         v;

  modport master (output start, x, y, b_i, input busy, done, d, b_o, v);
  modport slave  (input start, x, y, b_i, output busy, done, d, b_o, v);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: d = x - y - b_i, one bit per clock,
// LSB first, through one full-subtractor cell and a borrow flop.
module serial_sub #(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   xs_reg, xs_next;
  logic [W-1:0]   ys_reg, ys_next;
  logic [W-1:0]   acc_reg, acc_next;
  logic [W-1:0]   d_reg, d_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           bf_reg, bf_next;
  logic           bo_reg, bo_next;
  logic           v_reg, v_next;
  logic           xm_reg, xm_next;
  logic           ym_reg, ym_next;

  logic           diff;
  logic           borrow;
  logic [W-1:0]   shifted;

  assign diff   = xs_reg[0] ^ ys_reg[0] ^ bf_reg;
  assign borrow = (~xs_reg[0] & ys_reg[0]) | (~(xs_reg[0] ^ ys_reg[0]) & bf_reg);

  // New difference bit enters at the MSB so bit 0 ends up at d[0] after W shifts.
  generate
    if (W == 1) begin : g_one
      assign shifted = diff;
    end else begin : g_multi
      assign shifted = {diff, acc_reg[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      xs_reg    <= '0;
      ys_reg    <= '0;
      acc_reg   <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      bf_reg    <= 1'b0;
      bo_reg    <= 1'b0;
      v_reg     <= 1'b0;
      xm_reg    <= 1'b0;
      ym_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      xs_reg    <= xs_next;
      ys_reg    <= ys_next;
      acc_reg   <= acc_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      bf_reg    <= bf_next;
      bo_reg    <= bo_next;
      v_reg     <= v_next;
      xm_reg    <= xm_next;
      ym_reg    <= ym_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    xs_next    = xs_reg;
    ys_next    = ys_reg;
    acc_next   = acc_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    bf_next    = bf_reg;
    bo_next    = bo_reg;
    v_next     = v_reg;
    xm_next    = xm_reg;
    ym_next    = ym_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = RUN;
          xs_next    = bus.x;
          ys_next    = bus.y;
          bf_next    = bus.b_i;
          acc_next   = '0;
          cnt_next   = '0;
          xm_next    = bus.x[W-1];
          ym_next    = bus.y[W-1];
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        xs_next  = xs_reg >> 1;
        ys_next  = ys_reg >> 1;
        bf_next  = borrow;
        acc_next = shifted;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(W - 1)) begin
          // Outputs only move here, so they hold across RUN and IDLE.
          state_next = DONE;
          d_next     = shifted;
          bo_next    = borrow;
          v_next     = (xm_reg != ym_reg) & (diff != xm_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.d    = d_reg;
  assign bus.b_o  = bo_reg;
  assign bus.v    = v_reg;
endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised checks of serial_sub at W=4, W=1 and W=8.
module tb_serial_sub;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  serial_sub_if #(.W(4)) bus4 ();
  serial_sub_if #(.W(1)) bus1 ();
  serial_sub_if #(.W(8)) bus8 ();

  serial_sub #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_sub #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_sub #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    @(negedge clk);
    bus4.x = a; bus4.y = b; bus4.b_i = bi; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic wait4(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (bus4.done !== 1'b1 && lat < 40) begin
      if (bus4.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (bus4.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus4.busy); else pass_cnt++;
    total_cnt++; if (bus4.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus4.done); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h0) $display("FAIL reset_d: got %h want 0", bus4.d); else pass_cnt++;
    total_cnt++; if (bus4.b_o !== 1'b0) $display("FAIL reset_bo: got %b want 0", bus4.b_o); else pass_cnt++;
    total_cnt++; if (bus4.v !== 1'b0) $display("FAIL reset_v: got %b want 0", bus4.v); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, busy_n;
    launch4(4'd9, 4'd3, 1'b0);
    wait4(lat, busy_n);
    $display("op W=4 9-3-0 -> d=%h b_o=%b v=%b lat=%0d", bus4.d, bus4.b_o, bus4.v, lat);
    total_cnt++; if (lat != 4) $display("FAIL basic_latency: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (busy_n != 4) $display("FAIL basic_busy_cycles: got %0d want 4", busy_n); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h6) $display("FAIL basic_d: got %h want 6", bus4.d); else pass_cnt++;
    total_cnt++; if (bus4.b_o !== 1'b0) $display("FAIL basic_bo: got %b want 0", bus4.b_o); else pass_cnt++;
    // -7 - 3 = -10 does not fit in 4 bits, so the overflow flag is set.
    total_cnt++; if (bus4.v !== 1'b1) $display("FAIL basic_v: got %b want 1", bus4.v); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus4.done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", bus4.done); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h6) $display("FAIL basic_d_hold: got %h want 6", bus4.d); else pass_cnt++;
  endtask

  task automatic test_borrow();
    int lat, busy_n;
    logic [3:0] xa [3] = '{4'd3, 4'd0, 4'd8};
    logic [3:0] ya [3] = '{4'd9, 4'd0, 4'd1};
    logic       ba [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] ed [3] = '{4'hA, 4'hF, 4'h7};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    logic       ev [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      launch4(xa[i], ya[i], ba[i]);
      wait4(lat, busy_n);
      $display("op W=4 %0d-%0d-%0d -> d=%h b_o=%b v=%b", xa[i], ya[i], ba[i], bus4.d, bus4.b_o, bus4.v);
      total_cnt++; if (lat != 4) $display("FAIL borrow_latency[%0d]: got %0d want 4", i, lat); else pass_cnt++;
      total_cnt++; if (bus4.d !== ed[i]) $display("FAIL borrow_d[%0d]: got %h want %h", i, bus4.d, ed[i]); else pass_cnt++;
      total_cnt++; if (bus4.b_o !== eb[i]) $display("FAIL borrow_bo[%0d]: got %b want %b", i, bus4.b_o, eb[i]); else pass_cnt++;
      total_cnt++; if (bus4.v !== ev[i]) $display("FAIL borrow_v[%0d]: got %b want %b", i, bus4.v, ev[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int lat, busy_n, extra;
    launch4(4'd5, 4'd2, 1'b0);
    @(negedge clk);
    bus4.x = 4'd1; bus4.y = 4'd1; bus4.b_i = 1'b0; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    wait4(lat, busy_n);
    $display("op W=4 5-2-0 (start mid-run ignored) -> d=%h b_o=%b v=%b", bus4.d, bus4.b_o, bus4.v);
    total_cnt++; if (lat != 2) $display("FAIL ignore_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h3) $display("FAIL ignore_d: got %h want 3", bus4.d); else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) extra++;
    end
    total_cnt++; if (extra != 0) $display("FAIL ignore_extra_done: got %0d want 0", extra); else pass_cnt++;
    total_cnt++; if (bus4.busy !== 1'b0) $display("FAIL ignore_idle_busy: got %b want 0", bus4.busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    launch4(4'd6, 4'd1, 1'b0);
    wait4(lat, busy_n);
    $display("op W=4 6-1-0 -> d=%h b_o=%b v=%b", bus4.d, bus4.b_o, bus4.v);
    total_cnt++; if (bus4.d !== 4'h5) $display("FAIL b2b_first_d: got %h want 5", bus4.d); else pass_cnt++;
    bus4.x = 4'd7; bus4.y = 4'd7; bus4.b_i = 1'b0; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    total_cnt++; if (bus4.done !== 1'b0) $display("FAIL b2b_done_drop: got %b want 0", bus4.done); else pass_cnt++;
    total_cnt++; if (bus4.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus4.busy); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h5) $display("FAIL b2b_d_hold: got %h want 5", bus4.d); else pass_cnt++;
    wait4(lat, busy_n);
    $display("op W=4 7-7-0 (back-to-back) -> d=%h b_o=%b v=%b", bus4.d, bus4.b_o, bus4.v);
    total_cnt++; if (lat != 4) $display("FAIL b2b_latency: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h0) $display("FAIL b2b_d: got %h want 0", bus4.d); else pass_cnt++;
    total_cnt++; if (bus4.b_o !== 1'b0) $display("FAIL b2b_bo: got %b want 0", bus4.b_o); else pass_cnt++;
    total_cnt++; if (bus4.v !== 1'b0) $display("FAIL b2b_v: got %b want 0", bus4.v); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int lat, busy_n;
    launch4(4'd3, 4'd9, 1'b0);
    wait4(lat, busy_n);
    total_cnt++; if (bus4.d !== 4'hA) $display("FAIL areset_pre_d: got %h want a", bus4.d); else pass_cnt++;
    launch4(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("op W=4 async reset mid-run -> busy=%b done=%b d=%h b_o=%b v=%b", bus4.busy, bus4.done, bus4.d, bus4.b_o, bus4.v);
    total_cnt++; if (bus4.busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", bus4.busy); else pass_cnt++;
    total_cnt++; if (bus4.done !== 1'b0) $display("FAIL areset_done: got %b want 0", bus4.done); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h0) $display("FAIL areset_d: got %h want 0", bus4.d); else pass_cnt++;
    total_cnt++; if (bus4.b_o !== 1'b0) $display("FAIL areset_bo: got %b want 0", bus4.b_o); else pass_cnt++;
    total_cnt++; if (bus4.v !== 1'b0) $display("FAIL areset_v: got %b want 0", bus4.v); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    launch4(4'd8, 4'd1, 1'b0);
    wait4(lat, busy_n);
    $display("op W=4 8-1-0 after reset -> d=%h b_o=%b v=%b", bus4.d, bus4.b_o, bus4.v);
    total_cnt++; if (lat != 4) $display("FAIL areset_post_latency: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (bus4.d !== 4'h7) $display("FAIL areset_post_d: got %h want 7", bus4.d); else pass_cnt++;
    total_cnt++; if (bus4.b_o !== 1'b0) $display("FAIL areset_post_bo: got %b want 0", bus4.b_o); else pass_cnt++;
    total_cnt++; if (bus4.v !== 1'b1) $display("FAIL areset_post_v: got %b want 1", bus4.v); else pass_cnt++;
  endtask

  task automatic test_sweep_w1();
    int lat, fails;
    logic a, b, bi, prev_d, stable, ed, eb, ev;
    fails = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); bi = 1'($urandom_range(0, 1));
      @(negedge clk);
      prev_d = bus1.d;
      bus1.x = a; bus1.y = b; bus1.b_i = bi; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      lat = 0; stable = 1'b1;
      while (bus1.done !== 1'b1 && lat < 20) begin
        if (bus1.d !== prev_d) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
      ed = a ^ b ^ bi;
      eb = (int'(a) < int'(b) + int'(bi));
      ev = (a != b) && (ed != a);
      total_cnt++; if (lat != 1) $display("FAIL w1_latency[%0d]: got %0d want 1", n, lat); else pass_cnt++;
      total_cnt++; if (bus1.d !== ed) $display("FAIL w1_d[%0d] %b-%b-%b: got %b want %b", n, a, b, bi, bus1.d, ed); else pass_cnt++;
      total_cnt++; if (bus1.b_o !== eb) $display("FAIL w1_bo[%0d]: got %b want %b", n, bus1.b_o, eb); else pass_cnt++;
      total_cnt++; if (bus1.v !== ev) $display("FAIL w1_v[%0d]: got %b want %b", n, bus1.v, ev); else pass_cnt++;
      total_cnt++; if (stable !== 1'b1) $display("FAIL w1_d_stable[%0d]: got %b want 1", n, stable); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus1.done !== 1'b0) $display("FAIL w1_done_width[%0d]: got %b want 0", n, bus1.done); else pass_cnt++;
    end
    $display("sweep W=1: 1000 ops done");
  endtask

  task automatic test_sweep_w8();
    int lat;
    logic [7:0] a, b, prev_d, ed;
    logic [8:0] t;
    logic bi, stable, eb, ev;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); bi = 1'($urandom_range(0, 1));
      if (n == 0) begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
      if (n == 1) begin a = 8'h80; b = 8'h7F; bi = 1'b0; end
      @(negedge clk);
      prev_d = bus8.d;
      bus8.x = a; bus8.y = b; bus8.b_i = bi; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      lat = 0; stable = 1'b1;
      while (bus8.done !== 1'b1 && lat < 40) begin
        if (bus8.d !== prev_d) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
      t  = 9'(int'(a) - int'(b) - int'(bi) + 512);
      ed = t[7:0];
      eb = (int'(a) < int'(b) + int'(bi));
      ev = (a[7] != b[7]) && (ed[7] != a[7]);
      total_cnt++; if (lat != 8) $display("FAIL w8_latency[%0d]: got %0d want 8", n, lat); else pass_cnt++;
      total_cnt++; if (bus8.d !== ed) $display("FAIL w8_d[%0d] %h-%h-%b: got %h want %h", n, a, b, bi, bus8.d, ed); else pass_cnt++;
      total_cnt++; if (bus8.b_o !== eb) $display("FAIL w8_bo[%0d]: got %b want %b", n, bus8.b_o, eb); else pass_cnt++;
      total_cnt++; if (bus8.v !== ev) $display("FAIL w8_v[%0d]: got %b want %b", n, bus8.v, ev); else pass_cnt++;
      total_cnt++; if (stable !== 1'b1) $display("FAIL w8_d_stable[%0d]: got %b want 1", n, stable); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus8.done !== 1'b0) $display("FAIL w8_done_width[%0d]: got %b want 0", n, bus8.done); else pass_cnt++;
    end
    $display("sweep W=8: 1000 ops done");
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.x = '0; bus4.y = '0; bus4.b_i = 1'b0;
    bus1.start = 1'b0; bus1.x = '0; bus1.y = '0; bus1.b_i = 1'b0;
    bus8.start = 1'b0; bus8.x = '0; bus8.y = '0; bus8.b_i = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_sweep_w1();
    test_sweep_w8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
